// File: rtl/arith_seq_mac.sv
// Sequential arithmetic unit: registered add, iterative shift-add multiply, and
// saturating multiply-accumulate, all behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands and mode latched when start is seen
// ADD   | one-cycle add, or accumulator clear for CLR
// MUL   | shift-add multiply, one multiplier bit per cycle (MUL and MAC)
// FIN   | reserved encoding, never entered; recovers to IDLE
module arith_seq_mac #(
  parameter int SIZE_ADDER = 8,
  parameter int SIZE_MULT  = 6,
  parameter int ACC_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [SIZE_ADDER-1:0]    A,
  input  logic [SIZE_ADDER-1:0]    B,
  input  logic [SIZE_MULT-1:0]     C,
  input  logic [SIZE_MULT-1:0]     D,
  output logic                     busy,
  output logic                     done,
  output logic [SIZE_ADDER:0]      Sum,
  output logic [2*SIZE_MULT-1:0]   Product,
  output logic [ACC_W-1:0]         Acc,
  output logic                     acc_ovf
);

  localparam int PW = 2 * SIZE_MULT;
  localparam int CW = $clog2(SIZE_MULT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_MUL = 2'b01;
  localparam logic [1:0] M_MAC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  if (ACC_W < 2 * SIZE_MULT) begin : g_acc_w_check
    $error("arith_seq_mac: ACC_W must be >= 2*SIZE_MULT");
  end

  logic [1:0]            state;
  logic [1:0]            op_mode;
  logic [SIZE_ADDER-1:0] a_q;
  logic [SIZE_ADDER-1:0] b_q;
  logic [PW-1:0]         mcand;
  logic [SIZE_MULT-1:0]  mplier;
  logic [PW-1:0]         partial;
  logic [CW-1:0]         cnt;

  logic [PW-1:0]         partial_nxt;
  logic [ACC_W:0]        acc_sum;

  always_comb begin
    partial_nxt = partial + (mplier[0] ? mcand : '0);
    acc_sum     = {1'b0, Acc} + (ACC_W+1)'(partial_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_mode <= M_ADD;
      a_q     <= '0;
      b_q     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Product <= '0;
      Acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_mode <= mode;
            a_q     <= A;
            b_q     <= B;
            mcand   <= PW'(C);
            mplier  <= D;
            partial <= '0;
            // down-counter: terminal count 0 marks the last multiplier bit
            cnt     <= CW'(SIZE_MULT - 1);
            busy    <= 1'b1;
            state   <= (mode == M_ADD || mode == M_CLR) ? S_ADD : S_MUL;
          end
        end
        S_ADD: begin
          if (op_mode == M_CLR) begin
            Acc     <= '0;
            acc_ovf <= 1'b0;
          end else begin
            Sum <= {1'b0, a_q} + {1'b0, b_q};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_MUL: begin
          partial <= partial_nxt;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          if (cnt == '0) begin
            Product <= partial_nxt;
            if (op_mode == M_MAC) begin
              if (acc_sum[ACC_W]) begin
                Acc     <= '1;
                acc_ovf <= 1'b1;
              end else begin
                Acc <= acc_sum[ACC_W-1:0];
              end
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_mac.sv
// Randomized self-checking bench for arith_seq_mac with a plain-arithmetic
// reference model; ACC_W is narrowed so saturation is reachable.
module tb_arith_seq_mac;

  localparam int SA = 8;
  localparam int SM = 6;
  localparam int AW = 12;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      mode;
  logic [SA-1:0]   A, B;
  logic [SM-1:0]   C, D;
  logic            busy, done;
  logic [SA:0]     Sum;
  logic [2*SM-1:0] Product;
  logic [AW-1:0]   Acc;
  logic            acc_ovf;

  arith_seq_mac #(.SIZE_ADDER(SA), .SIZE_MULT(SM), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .A(A), .B(B), .C(C), .D(D),
    .busy(busy), .done(done), .Sum(Sum), .Product(Product),
    .Acc(Acc), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  longint exp_sum, exp_prod, exp_acc;
  longint exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".Sum"},     32'(Sum),     32'(exp_sum));
    chk({tag, ".Product"}, 32'(Product), 32'(exp_prod));
    chk({tag, ".Acc"},     32'(Acc),     32'(exp_acc));
    chk({tag, ".acc_ovf"}, 32'(acc_ovf), 32'(exp_ovf));
  endtask

  // Reference model: what each operation should leave behind.
  task automatic model_op(input logic [1:0] m, input int a, b, c, d);
    case (m)
      2'b00: exp_sum = longint'(a) + longint'(b);
      2'b01: exp_prod = longint'(c) * longint'(d);
      2'b10: begin
        exp_prod = longint'(c) * longint'(d);
        exp_acc  = exp_acc + exp_prod;
        if (exp_acc > ACC_MAX) begin
          exp_acc = ACC_MAX;
          exp_ovf = 1;
        end
      end
      default: begin
        exp_acc = 0;
        exp_ovf = 0;
      end
    endcase
  endtask

  // Entered #1 after an edge with the DUT idle or in its done cycle;
  // returns #1 after the edge that raised done.
  task automatic run_op(input string tag, input logic [1:0] m, input int a, b, c, d,
                        input bit noise);
    int lat;
    int exp_lat;
    bit seen;
    mode = m; A = SA'(a); B = SA'(b); C = SM'(c); D = SM'(d); start = 1'b1;
    model_op(m, a, b, c, d);
    exp_lat = (m == 2'b00 || m == 2'b11) ? 1 : SM;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (noise) begin
        A = SA'($urandom); B = SA'($urandom);
        C = SM'($urandom); D = SM'($urandom);
        mode = 2'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        lat  = i;
      end else begin
        chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_outs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".busy_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00;
    A = '0; B = '0; C = '0; D = '0;
    exp_sum = 0; exp_prod = 0; exp_acc = 0; exp_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    rst = 1'b0;
    idle_cycle("post_reset");

    run_op("add_max", 2'b00, 255, 255, 0, 0, 0);
    idle_cycle("add_max");

    run_op("mul_20x60", 2'b01, 0, 0, 20, 60, 0);
    idle_cycle("mul_20x60");
    run_op("mul_63x63", 2'b01, 0, 0, 63, 63, 0);
    idle_cycle("mul_63x63");
    run_op("mul_0x50", 2'b01, 0, 0, 0, 50, 0);
    idle_cycle("mul_0x50");

    // start and new operands toggled throughout the multiply must be ignored
    run_op("mul_noise", 2'b01, 0, 0, 30, 10, 1);
    idle_cycle("mul_noise");

    run_op("b2b_add", 2'b00, 17, 200, 0, 0, 0);
    run_op("b2b_mul", 2'b01, 0, 0, 40, 20, 0);
    idle_cycle("b2b_mul");

    run_op("clr0", 2'b11, 0, 0, 0, 0, 0);
    run_op("mac1", 2'b10, 0, 0, 63, 63, 0);
    run_op("mac2", 2'b10, 0, 0, 63, 63, 0);
    run_op("clr1", 2'b11, 0, 0, 0, 0, 0);
    idle_cycle("clr1");

    // reset lands on edge 3 of a multiply
    mode = 2'b01; C = SM'(10); D = SM'(50); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sum = 0; exp_prod = 0; exp_acc = 0; exp_ovf = 0;
    check_outs("rst_mid");
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    run_op("mul_after_rst", 2'b01, 0, 0, 10, 50, 0);
    idle_cycle("mul_after_rst");

    for (int k = 0; k < 60; k++) begin
      run_op("rand", 2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
